gowin_rpll: RTL and testbench



---
 rtl/clkgen_pkg.sv | 33 +++
 rtl/reset_sync.sv | 24 ++
 rtl/gowin_rpll.sv | 98 +++++++++
 tb/tb_gowin_rpll.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared definitions for the digital clock synthesizer family.
//   clog2               : ceil(log2(n)), constant-foldable
//   VGA_NUM / VGA_DEN   : 100 MHz -> 25.2 MHz ratio for 640x480 timing
//   `CLKGEN_CHECK(c, l) : elaboration-time parameter guard; emits a named
//                         generate block that raises $error when c is false
`ifndef CLKGEN_PKG_SV
`define CLKGEN_PKG_SV

`define CLKGEN_CHECK(cond, lbl) \
  if (!(cond)) begin : lbl \
    $error("clkgen: illegal parameter set"); \
  end

package clkgen_pkg;

  localparam int VGA_NUM = 63;
  localparam int VGA_DEN = 250;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: assertion is asynchronous, deassertion is
// aligned to clkin so rstn_s rises on the 2nd clkin edge after rst_n goes high.
//   clkin  : reference clock
//   rst_n  : raw asynchronous active-low reset
//   rstn_s : synchronized active-low reset
module reset_sync (
  input  logic clkin,
  input  logic rst_n,
  output logic rstn_s
);

  logic meta;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      rstn_s <= 1'b0;
    end else begin
      meta   <= 1'b1;
      rstn_s <= meta;
    end
  end

endmodule

// File: rtl/gowin_rpll.sv
// Rational phase-accumulator clock synthesizer standing in for the vendor
// rPLL. f_clkout = f_clkin*NUM/DEN, jitter bounded by one clkin period.
//   clkin   : reference clock, sole clock of the block
//   rst_n   : asynchronous active-low reset
//   clkout  : synthesized clock (registered)
//   clkoutd : clkout / SDIV (registered)
//   lock    : set after LOCK_CNT clkout rises, held until reset
module gowin_rpll
  import clkgen_pkg::*;
#(
  parameter int NUM      = VGA_NUM,
  parameter int DEN      = VGA_DEN,
  parameter int SDIV     = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic clkin,
  input  logic rst_n,
  output logic clkout,
  output logic clkoutd,
  output logic lock
);

  `CLKGEN_CHECK(NUM >= 1, g_chk_num)
  `CLKGEN_CHECK(2 * NUM <= DEN, g_chk_ratio)
  `CLKGEN_CHECK((SDIV % 2 == 0) && (SDIV >= 2), g_chk_sdiv)
  `CLKGEN_CHECK(LOCK_CNT >= 1, g_chk_lock)

  // acc < DEN and 2*NUM <= DEN, so acc+2*NUM < 2*DEN fits in clog2(DEN)+1 bits
  localparam int AW = clog2(DEN) + 1;
  localparam int DW = (SDIV / 2 > 1) ? clog2(SDIV / 2) : 1;
  localparam int LW = clog2(LOCK_CNT + 1);

  localparam logic [AW-1:0] STEP  = AW'(2 * NUM);
  localparam logic [AW-1:0] DENV  = AW'(DEN);
  localparam logic [DW-1:0] DLAST = DW'(SDIV / 2 - 1);
  localparam logic [LW-1:0] LMAX  = LW'(LOCK_CNT);

  logic          rstn_s;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          tgl;
  logic          rise;
  logic [DW-1:0] dcnt;
  logic [LW-1:0] lcnt;

  reset_sync u_rst (
    .clkin  (clkin),
    .rst_n  (rst_n),
    .rstn_s (rstn_s)
  );

  // Each toggle is a half period; 2*NUM toggles per DEN clkin cycles.
  // rise marks the edge on which clkout's register goes 0->1, so the divider
  // and lock counter advance on the very same clkin edge as clkout rises.
  always_comb begin
    sum  = acc + STEP;
    tgl  = (sum >= DENV);
    rise = tgl & ~clkout;
  end

  always_ff @(posedge clkin or negedge rstn_s) begin
    if (!rstn_s) begin
      acc    <= '0;
      clkout <= 1'b0;
    end else if (tgl) begin
      acc    <= sum - DENV;
      clkout <= ~clkout;
    end else begin
      acc    <= sum;
    end
  end

  always_ff @(posedge clkin or negedge rstn_s) begin
    if (!rstn_s) begin
      dcnt    <= '0;
      clkoutd <= 1'b0;
    end else if (rise) begin
      if (dcnt == DLAST) begin
        dcnt    <= '0;
        clkoutd <= ~clkoutd;
      end else begin
        dcnt    <= dcnt + DW'(1);
      end
    end
  end

  // Saturating rise counter; lock is sticky until the next reset.
  always_ff @(posedge clkin or negedge rstn_s) begin
    if (!rstn_s) begin
      lcnt <= '0;
      lock <= 1'b0;
    end else if (rise && (lcnt != LMAX)) begin
      lcnt <= lcnt + LW'(1);
      if (lcnt == LMAX - LW'(1)) lock <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gowin_rpll.sv
// Self-checking bench for gowin_rpll. Four instances with different ratios
// share clkin/rst_n; expected outputs come from closed-form arithmetic on the
// number of clkin edges k seen since the synchronized reset released:
//   toggles t = floor(2*NUM*k/DEN), clkout = t odd, rises r = ceil(t/2),
//   clkoutd = floor(r/(SDIV/2)) odd, lock = (r >= LOCK_CNT).
module tb_gowin_rpll;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] co, cd, lk;
  int         total = 0;
  int         bad   = 0;
  int         e     = 0;

  gowin_rpll #(.NUM(1),  .DEN(4),   .SDIV(2), .LOCK_CNT(16)) u_a (
    .clkin(clkin), .rst_n(rst_n), .clkout(co[0]), .clkoutd(cd[0]), .lock(lk[0]));
  gowin_rpll #(.NUM(63), .DEN(250), .SDIV(2), .LOCK_CNT(16)) u_b (
    .clkin(clkin), .rst_n(rst_n), .clkout(co[1]), .clkoutd(cd[1]), .lock(lk[1]));
  gowin_rpll #(.NUM(63), .DEN(250), .SDIV(6), .LOCK_CNT(5))  u_c (
    .clkin(clkin), .rst_n(rst_n), .clkout(co[2]), .clkoutd(cd[2]), .lock(lk[2]));
  gowin_rpll #(.NUM(1),  .DEN(2),   .SDIV(2), .LOCK_CNT(1))  u_d (
    .clkin(clkin), .rst_n(rst_n), .clkout(co[3]), .clkoutd(cd[3]), .lock(lk[3]));

  always #5 clkin = ~clkin;

  // clkin edges since rst_n release; the first two only clock the synchronizer
  always @(posedge clkin or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  function automatic int kk();
    return (e > 2) ? e - 2 : 0;
  endfunction

  function automatic logic [2:0] ref_out(int num, int den, int sdiv, int lck, int k);
    int t, r, d;
    t = (2 * num * k) / den;
    r = (t + 1) / 2;
    d = r / (sdiv / 2);
    return {(r >= lck), d[0], t[0]};
  endfunction

  function automatic logic [2:0] ref_dut(int i, int k);
    case (i)
      0:       return ref_out(1, 4, 2, 16, k);
      1:       return ref_out(63, 250, 2, 16, k);
      2:       return ref_out(63, 250, 6, 5, k);
      default: return ref_out(1, 2, 2, 1, k);
    endcase
  endfunction

  function automatic logic [2:0] obs(int i);
    return {lk[i], cd[i], co[i]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clkin);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs(i) !== 3'b000) begin
        bad++;
        $display("FAIL reset_hold dut%0d got=%b exp=000", i, obs(i));
      end
    end
    #2 rst_n = 1'b1;
    // synchronizer latency: nothing may move on the first two edges
    repeat (2) begin
      @(negedge clkin);
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs(i) !== 3'b000) begin
          bad++;
          $display("FAIL reset_sync dut%0d e=%0d got=%b exp=000", i, e, obs(i));
        end
      end
    end
  endtask

  task automatic test_ratio_1_4();
    repeat (40) begin
      @(negedge clkin);
      total++;
      if (obs(0) !== ref_dut(0, kk())) begin
        bad++;
        $display("FAIL ratio_1_4 k=%0d got=%b exp=%b", kk(), obs(0), ref_dut(0, kk()));
      end
    end
  endtask

  task automatic test_lock();
    int k;
    repeat (1060) begin
      @(negedge clkin);
      k = kk();
      total++;
      if (obs(0) !== ref_dut(0, k)) begin
        bad++;
        $display("FAIL lock_seq k=%0d got=%b exp=%b", k, obs(0), ref_dut(0, k));
      end
      // 16th rise of a 1/4 ratio lands at k=62; lock must hold from there on
      if (k >= 62) begin
        total++;
        if (lk[0] !== 1'b1) begin
          bad++;
          $display("FAIL lock_hold k=%0d got=%b exp=1", k, lk[0]);
        end
      end
    end
  endtask

  task automatic test_defaults();
    logic hist[$];
    int   s, n, run, max_run, min_run, first;
    repeat (600) begin
      @(negedge clkin);
      hist.push_back(co[1]);
      total++;
      if (obs(1) !== ref_dut(1, kk())) begin
        bad++;
        $display("FAIL defaults k=%0d got=%b exp=%b", kk(), obs(1), ref_dut(1, kk()));
      end
    end
    for (int w = 0; w < 3; w++) begin
      s = $urandom_range(0, 600 - 251);
      n = 0;
      for (int j = s; j < s + 250; j++) if (hist[j] != hist[j+1]) n++;
      total++;
      if (n !== 126) begin
        bad++;
        $display("FAIL toggle_window start=%0d got=%0d exp=126", s, n);
      end
    end
    // interior phase lengths (partial first/last phase skipped)
    max_run = 0; min_run = 1000; run = 0; first = 1;
    for (int j = 1; j < 600; j++) begin
      run++;
      if (hist[j] != hist[j-1]) begin
        if (!first) begin
          if (run > max_run) max_run = run;
          if (run < min_run) min_run = run;
        end
        first = 0;
        run = 0;
      end
    end
    total++;
    if (max_run !== 2 || min_run !== 1) begin
      bad++;
      $display("FAIL phase_len got=min%0d/max%0d exp=min1/max2", min_run, max_run);
    end
  endtask

  task automatic test_divider();
    int k, rises, dtog;
    logic pco, pcd;
    rises = 0; dtog = 0;
    pco = co[2]; pcd = cd[2];
    repeat (400) begin
      @(negedge clkin);
      k = kk();
      for (int i = 1; i <= 2; i++) begin
        total++;
        if (obs(i) !== ref_dut(i, k)) begin
          bad++;
          $display("FAIL divider dut%0d k=%0d got=%b exp=%b", i, k, obs(i), ref_dut(i, k));
        end
      end
      if (!pco && co[2]) rises++;
      if (pcd != cd[2]) dtog++;
      pco = co[2]; pcd = cd[2];
    end
    total++;
    if (dtog < rises / 3 - 1 || dtog > rises / 3 + 1) begin
      bad++;
      $display("FAIL div6_rate got=%0d toggles exp~%0d (rises=%0d)", dtog, rises / 3, rises);
    end
  endtask

  task automatic test_mid_reset();
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(20, 200)) @(negedge clkin);
      #($urandom_range(1, 4)) rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs(i) !== 3'b000) begin
          bad++;
          $display("FAIL midrst_async dut%0d got=%b exp=000", i, obs(i));
        end
      end
      repeat ($urandom_range(1, 4)) @(negedge clkin);
      #($urandom_range(1, 3)) rst_n = 1'b1;
      repeat (300) begin
        @(negedge clkin);
        for (int i = 0; i < 4; i++) begin
          total++;
          if (obs(i) !== ref_dut(i, kk())) begin
            bad++;
            $display("FAIL midrst_replay dut%0d k=%0d got=%b exp=%b", i, kk(), obs(i), ref_dut(i, kk()));
          end
        end
      end
    end
  endtask

  task automatic test_half();
    logic prev;
    prev = co[3];
    repeat (60) begin
      @(negedge clkin);
      total++;
      if (obs(3) !== ref_dut(3, kk())) begin
        bad++;
        $display("FAIL half_rate k=%0d got=%b exp=%b", kk(), obs(3), ref_dut(3, kk()));
      end
      total++;
      if (co[3] !== ~prev) begin
        bad++;
        $display("FAIL half_toggle k=%0d got=%b exp=%b", kk(), co[3], ~prev);
      end
      prev = co[3];
    end
  endtask

  initial begin
    test_reset();
    test_ratio_1_4();
    test_lock();
    test_defaults();
    test_divider();
    test_mid_reset();
    test_half();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
